// File: rtl/f_fetch.sv
// f_fetch: instruction fetch stage with one outstanding memory request and a
// 2-entry {instr,pc} buffer feeding the decode-stage register.
`default_nettype none

module f_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_stall,
  input  logic        in_redirect,
  input  logic [31:0] in_redirect_pc,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_valid,
  input  logic [31:0] in_imem_rdata,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]  count_q, count_d;

  logic        push;
  logic        pop;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign redirect_target      = {in_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^in_redirect_pc[1:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect while a response is still owed parks in DRAIN
  always_comb begin
    state_d = state_q;
    if (in_redirect) begin
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !in_imem_valid) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE:  if (out_imem_req) state_d = S_WAIT;
        S_WAIT:  if (in_imem_valid) state_d = S_IDLE;
        S_DRAIN: if (in_imem_valid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs; a request is only made when the buffer has room for its response
  always_comb begin
    out_imem_req  = reset && (state_q == S_IDLE) && (count_q < 2'd2) && !in_redirect;
    out_imem_addr = fetch_pc_q;
    push          = (state_q == S_WAIT) && in_imem_valid && !in_redirect;
    out_valid     = (count_q != 2'd0);
    pop           = out_valid && !in_stall && !in_redirect;
    out_instr     = out_valid ? instr0_q : 32'h0;
    out_pc        = out_valid ? pc0_q : 32'h0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    if (in_redirect) begin
      fetch_pc_d = redirect_target;
    end else if (out_imem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_addr_d = fetch_pc_q;
    end
  end

  // Buffer update; slot 0 is always the head
  always_comb begin
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    count_d  = count_q;
    if (in_redirect) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            instr0_d = in_imem_rdata;
            pc0_d    = req_addr_q;
          end else begin
            instr1_d = in_imem_rdata;
            pc1_d    = req_addr_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          instr0_d = instr1_q;
          pc0_d    = pc1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            instr0_d = in_imem_rdata;
            pc0_d    = req_addr_q;
          end else begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
            instr1_d = in_imem_rdata;
            pc1_d    = req_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr0_q   <= 32'h0;
      instr1_q   <= 32'h0;
      pc0_q      <= 32'h0;
      pc1_q      <= 32'h0;
      count_q    <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      count_q    <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_f_fetch.sv
// tb_f_fetch: scoreboard bench for f_fetch with a variable-latency memory model.
`default_nettype none

module tb_f_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        in_stall;
  logic        in_redirect;
  logic [31:0] in_redirect_pc;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_valid;
  logic [31:0] in_imem_rdata;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_valid;

  // memory model state
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_pend;
  int          mem_cd;
  logic [31:0] mem_pa;
  int          lat;
  logic        force_valid;
  logic [31:0] force_data;

  // scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic        stale;

  int n_pass;
  int n_chk;

  assign in_imem_valid = mem_valid | force_valid;
  assign in_imem_rdata = force_valid ? force_data : mem_rdata;

  f_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_stall      (in_stall),
    .in_redirect   (in_redirect),
    .in_redirect_pc(in_redirect_pc),
    .out_imem_req  (out_imem_req),
    .out_imem_addr (out_imem_addr),
    .in_imem_valid (in_imem_valid),
    .in_imem_rdata (in_imem_rdata),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_valid     (out_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: answers each accepted request 'lat' cycles later; reset drops it.
  initial begin
    logic        acc;
    logic [31:0] aa;
    logic        r;
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
    mem_pend  = 1'b0;
    mem_cd    = 0;
    mem_pa    = 32'h0;
    forever begin
      @(negedge clk);
      acc = out_imem_req;
      aa  = out_imem_addr;
      if (!reset) mem_pend = 1'b0;
      @(posedge clk);
      r = reset;
      #1;
      mem_valid = 1'b0;
      if (!r) mem_pend = 1'b0;
      if (acc && r) begin
        mem_pend = 1'b1;
        mem_cd   = lat;
        mem_pa   = aa;
      end
      if (mem_pend) begin
        if (mem_cd <= 1) begin
          mem_valid = 1'b1;
          mem_rdata = mem_word(mem_pa);
          mem_pend  = 1'b0;
        end else begin
          mem_cd--;
        end
      end
    end
  end

  // Scoreboard: decides at mid-cycle what the coming edge must do.
  initial begin
    logic [63:0] e;
    exp_fetch = RESET_PC;
    stale     = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        exp_fetch = RESET_PC;
        stale     = 1'b0;
      end else begin
        check("valid_vs_model", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
        if (in_redirect) begin
          check("redirect_noreq", {31'h0, out_imem_req}, 32'h0);
          exp_q.delete();
          exp_fetch = {in_redirect_pc[31:2], 2'b00};
          if (mem_pend) stale = 1'b1;
        end else begin
          if (out_imem_req) begin
            check("req_addr", out_imem_addr, exp_fetch);
            check("req_room", {31'h0, exp_q.size() < 2}, 32'h1);
            exp_fetch = exp_fetch + 32'd4;
          end
          if (exp_q.size() != 0 && !in_stall) begin
            e = exp_q.pop_front();
            check("head_pc", out_pc, e[63:32]);
            check("head_instr", out_instr, e[31:0]);
          end
          if (mem_valid) begin
            if (!stale) exp_q.push_back({mem_pa, mem_rdata});
            stale = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_req(output logic [31:0] addr);
    bit seen;
    seen = 1'b0;
    addr = 32'h0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_imem_req) begin
        seen = 1'b1;
        addr = out_imem_addr;
      end
    end
    if (!seen) check("req_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    reset          = 1'b0;
    in_stall       = 1'b0;
    in_redirect    = 1'b0;
    in_redirect_pc = 32'h0;
    force_valid    = 1'b0;
    force_data     = 32'h0;
    lat            = 1;
    n_pass         = 0;
    n_chk          = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_req", {31'h0, out_imem_req}, 32'h0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("first_req", {31'h0, out_imem_req}, 32'h1);
    check("first_addr", out_imem_addr, RESET_PC);
    repeat (12) @(posedge clk);

    // fill under stall from a fresh reset
    #2 reset = 1'b0;
    in_stall = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("stall_noreq", {31'h0, out_imem_req}, 32'h0);
    check("stall_pc", out_pc, RESET_PC);
    check("stall_instr", out_instr, mem_word(RESET_PC));
    in_stall = 1'b0;
    repeat (8) @(posedge clk);

    // redirect while WAIT, response one cycle later
    lat = 2;
    wait_req(a);
    in_redirect    = 1'b1;
    in_redirect_pc = 32'h0000_3105;
    @(posedge clk);
    #1;
    in_redirect = 1'b0;
    check("redir_empty", {31'h0, out_valid}, 32'h0);
    wait_req(a);
    check("redir_addr", a, 32'h0000_3104);
    repeat (6) @(posedge clk);
    #1;
    lat = 1;

    // redirect and stall together with a full buffer
    in_stall = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("full_noreq", {31'h0, out_imem_req}, 32'h0);
    check("full_valid", {31'h0, out_valid}, 32'h1);
    in_redirect    = 1'b1;
    in_redirect_pc = 32'h0000_5000;
    @(posedge clk);
    #1;
    in_redirect = 1'b0;
    in_stall    = 1'b0;
    check("flush_empty", {31'h0, out_valid}, 32'h0);
    check("flush_instr", out_instr, 32'h0);
    repeat (8) @(posedge clk);
    #1;

    // redirect to the top of the address space
    in_redirect    = 1'b1;
    in_redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    in_redirect = 1'b0;
    wait_req(a);
    check("wrap_top", a, 32'hFFFF_FFFC);
    wait_req(a);
    check("wrap_zero", a, 32'h0000_0000);
    repeat (4) @(posedge clk);

    // asynchronous reset while WAIT, then a late response in IDLE
    lat = 2;
    wait_req(a);
    #1 reset = 1'b0;
    #1;
    check("async_valid", {31'h0, out_valid}, 32'h0);
    check("async_pc", out_pc, 32'h0);
    check("async_instr", out_instr, 32'h0);
    check("async_req", {31'h0, out_imem_req}, 32'h0);
    @(posedge clk);
    #3 reset = 1'b1;
    force_data  = 32'hDEAD_BEEF;
    force_valid = 1'b1;
    #1;
    check("rerst_req", {31'h0, out_imem_req}, 32'h1);
    check("rerst_addr", out_imem_addr, RESET_PC);
    @(posedge clk);
    #1 force_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/f_fetch.md
F_FETCH -- requirements
Module: f_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; reset=0 clears state immediately, regardless of clk.
REQ-004 in_stall  input  1  hazard-unit stall; D-stage register holds; head entry not consumed.
REQ-005 in_redirect  input  1  branch/jump taken in D; flush and refetch.
REQ-006 in_redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-007 out_imem_req  output  1  instruction-memory request strobe; accepted the cycle it is high.
REQ-008 out_imem_addr  output  32  request address; bits [1:0] always 00.
REQ-009 in_imem_valid  input  1  response strobe; one response per request; arrives >=1 cycle after request.
REQ-010 in_imem_rdata  input  32  response instruction word, valid when in_imem_valid=1.
REQ-011 out_instr  output  32  instruction presented to D-stage register.
REQ-012 out_pc  output  32  PC of out_instr.
REQ-013 out_valid  output  1  1 = out_instr/out_pc hold a real fetched instruction.

Function
REQ-014 Block SHALL hold fetch_pc, a 2-entry {instr,pc} FIFO with count 0..2, and FSM states IDLE, WAIT, DRAIN.
REQ-015 At most one memory request SHALL be outstanding.
REQ-016 IDLE: out_imem_req=1, out_imem_addr=fetch_pc, when count plus outstanding responses <2 and in_redirect=0; same edge: fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), state -> WAIT.
REQ-017 WAIT: in_imem_valid=1 SHALL push {in_imem_rdata, address of that request} and return to IDLE; no new request is issued in the response cycle.
REQ-018 DRAIN: in_imem_valid=1 SHALL discard the response, push nothing, return to IDLE.
REQ-019 out_instr/out_pc SHALL be FIFO head, combinational from state; count=0 -> out_valid=0, out_instr=0, out_pc=0 (bubble = nop).
REQ-020 Head SHALL pop on an edge where out_valid=1, in_stall=0 and in_redirect=0; in_stall=1 holds FIFO contents.
REQ-021 Push and pop on the same edge SHALL leave count unchanged, order preserved; push when count=2 SHALL not occur (REQ-016 reservation).
REQ-022 in_redirect=1 SHALL, on that edge: empty FIFO (count=0), fetch_pc <= {in_redirect_pc[31:2],2'b00}, state -> DRAIN if WAIT with no response this cycle, else IDLE; no request is issued that cycle.
REQ-023 in_redirect SHALL take priority over in_stall, pop, and any response in the same cycle (response discarded).
REQ-024 Redirect latency: target instruction appears on out_instr no earlier than 2 edges after redirect edge (request, then response+push).
REQ-025 Unaligned responses or in_imem_valid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-026 reset=0 SHALL asynchronously set fetch_pc=RESET_PC, count=0, state=IDLE, out_valid=0, out_instr=0, out_pc=0, out_imem_req=0 while asserted.
REQ-027 Reset asserted mid-request SHALL drop the outstanding request; a response arriving after release while in IDLE SHALL be ignored.
REQ-028 After reset release, first request (addr=RESET_PC) SHALL be issued on the first rising edge with reset=1.

Verification
REQ-029 Reset release, 1-cycle memory, in_stall=0 -> requests 0x3000,0x3004,0x3008 every 2 cycles; out_pc follows same sequence with matching words, out_valid between.
REQ-030 in_stall=1 for 5 cycles with FIFO filled -> count reaches 2, out_imem_req stops, out_instr/out_pc constant; release -> 0x3000 then 0x3004 in order.
REQ-031 Redirect to 0x0000_3105 while WAIT, response next cycle -> response discarded, next request addr 0x0000_3104, FIFO empty, out_valid=0 until new push.
REQ-032 Redirect and in_stall=1 same cycle with count=2 -> FIFO flushed, stale instructions never reach out_instr.
REQ-033 Redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-034 reset=0 mid-cycle between edges while WAIT -> outputs zero immediately; late in_imem_valid after release ignored; first request 0x3000.
